design_select_ctrl: RTL and testbench

Sequencer that decides which of several wrapped designs sharing the tristated `wbs_dat_o` bus is enabled. It drives their `active` inputs. It guarantees at most one `active` bit is ever high, and it inserts a programmable all-off dead time between releasing one design and enabling the next, so the shared tristate bus never sees two drivers. It sits at the top level, beside the wrapped designs, and is fed by a simple valid/ready select request from the management side.

---
 rtl/design_select_ctrl.sv | 154 +++++++++++++++
 tb/tb_design_select_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/design_select_ctrl.sv
// design_select_ctrl
// Decides which wrapped design may drive the shared tristated wishbone
// data bus. At most one design is enabled at any time. Every switch
// passes through an all-off dead time so that a design that is still
// releasing the bus never overlaps the next one. All outputs come from
// registers, so no input can reach `active` through logic alone.
module design_select_ctrl #(
    parameter  int NUM_DESIGNS = 2,
    parameter  int DEAD_CYCLES = 4,
    localparam int ID_W        = $clog2(NUM_DESIGNS)
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_n,
    input  logic                   sel_valid,
    output logic                   sel_ready,
    input  logic                   sel_en,
    input  logic [ID_W-1:0]        sel_id,
    input  logic                   kill,
    output logic [NUM_DESIGNS-1:0] active,
    output logic [ID_W-1:0]        cur_id,
    output logic                   cur_on,
    output logic                   done,
    output logic                   err
);

    typedef enum logic [1:0] {
        ST_OFF = 2'd0,
        ST_ON  = 2'd1,
        ST_GAP = 2'd2
    } state_e;

    localparam logic [7:0]             GAP_LOAD = 8'(DEAD_CYCLES - 1);
    localparam logic [NUM_DESIGNS-1:0] ONE_HOT0 = {{(NUM_DESIGNS-1){1'b0}}, 1'b1};

    state_e                 state_q,  state_d;
    logic [7:0]             cnt_q,    cnt_d;
    logic [ID_W-1:0]        tgt_q,    tgt_d;
    logic [ID_W-1:0]        cur_id_q, cur_id_d;
    logic                   cur_on_q, cur_on_d;
    logic [NUM_DESIGNS-1:0] active_q, active_d;
    logic                   ready_q,  ready_d;
    logic                   done_q,   done_d;
    logic                   err_q,    err_d;

    logic                   accept_s;
    logic                   id_bad_s;

    assign accept_s = sel_valid & ready_q;
    // Widen before comparing so the check stays meaningful when NUM_DESIGNS
    // is a power of two and every id value is legal.
    assign id_bad_s = (32'(sel_id) >= NUM_DESIGNS);

    // Next-state and output decode; kill overrides any handshake.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tgt_d    = tgt_q;
        cur_id_d = cur_id_q;
        cur_on_d = cur_on_q;
        active_d = active_q;
        ready_d  = ready_q;
        done_d   = 1'b0;
        err_d    = 1'b0;

        if (kill) begin
            state_d  = ST_OFF;
            cnt_d    = 8'd0;
            cur_on_d = 1'b0;
            active_d = '0;
            ready_d  = 1'b1;
        end else begin
            case (state_q)
                ST_OFF, ST_ON: begin
                    if (accept_s) begin
                        if (sel_en) begin
                            if (id_bad_s) begin
                                err_d = 1'b1;
                            end else if ((state_q == ST_ON) && (sel_id == cur_id_q)) begin
                                done_d = 1'b1;
                            end else begin
                                // Any enable, even from OFF, pays the full dead time.
                                state_d  = ST_GAP;
                                tgt_d    = sel_id;
                                cnt_d    = GAP_LOAD;
                                cur_on_d = 1'b0;
                                active_d = '0;
                                ready_d  = 1'b0;
                            end
                        end else begin
                            state_d  = ST_OFF;
                            cur_on_d = 1'b0;
                            active_d = '0;
                            done_d   = 1'b1;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_GAP: begin
                    if (cnt_q == 8'd0) begin
                        state_d  = ST_ON;
                        cur_id_d = tgt_q;
                        cur_on_d = 1'b1;
                        active_d = ONE_HOT0 << tgt_q;
                        ready_d  = 1'b1;
                        done_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                default: begin
                    state_d  = ST_OFF;
                    cnt_d    = 8'd0;
                    cur_on_d = 1'b0;
                    active_d = '0;
                    ready_d  = 1'b1;
                end
            endcase
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q  <= ST_OFF;
            cnt_q    <= 8'd0;
            tgt_q    <= '0;
            cur_id_q <= '0;
            cur_on_q <= 1'b0;
            active_q <= '0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tgt_q    <= tgt_d;
            cur_id_q <= cur_id_d;
            cur_on_q <= cur_on_d;
            active_q <= active_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign sel_ready = ready_q;
    assign active    = active_q;
    assign cur_id    = cur_id_q;
    assign cur_on    = cur_on_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_design_select_ctrl.sv
// Directed bench for design_select_ctrl with three designs (so that an
// out-of-range id is representable) and a dead time of four cycles.
// A background monitor checks one-hot-or-zero and the minimum gap.
module tb_design_select_ctrl;

    localparam int ND   = 3;
    localparam int DEAD = 4;
    localparam int IW   = $clog2(ND);

    logic          clk;
    logic          rst_n;
    logic          sel_valid;
    logic          sel_ready;
    logic          sel_en;
    logic [IW-1:0] sel_id;
    logic          kill;
    logic [ND-1:0] active;
    logic [IW-1:0] cur_id;
    logic          cur_on;
    logic          done;
    logic          err;

    int n_checks;
    int n_errors;

    design_select_ctrl #(
        .NUM_DESIGNS (ND),
        .DEAD_CYCLES (DEAD)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_n  (rst_n),
        .sel_valid (sel_valid),
        .sel_ready (sel_ready),
        .sel_en    (sel_en),
        .sel_id    (sel_id),
        .kill      (kill),
        .active    (active),
        .cur_id    (cur_id),
        .cur_on    (cur_on),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one edge, then withdraw it.
    task automatic req(input logic en, input logic [IW-1:0] id);
        sel_valid = 1'b1;
        sel_en    = en;
        sel_id    = id;
        step();
        sel_valid = 1'b0;
        sel_en    = 1'b0;
        sel_id    = '0;
    endtask

    // Full switch to `id`, checking the dead-time shape and done timing.
    task automatic switch_to(input string tag, input logic [IW-1:0] id);
        req(1'b1, id);
        for (int i = 0; i < DEAD; i++) begin
            if (i > 0) step();
            chk({tag, "_gap_active"}, 32'(active), 32'd0);
            chk({tag, "_gap_ready"},  32'(sel_ready), 32'd0);
            chk({tag, "_gap_done"},   32'(done), 32'd0);
        end
        step();
        chk({tag, "_on_active"}, 32'(active), 32'(3'b001 << id));
        chk({tag, "_on_curid"},  32'(cur_id), 32'(id));
        chk({tag, "_on_curon"},  32'(cur_on), 32'd1);
        chk({tag, "_on_done"},   32'(done), 32'd1);
        chk({tag, "_on_ready"},  32'(sel_ready), 32'd1);
        step();
        chk({tag, "_done_clr"},  32'(done), 32'd0);
    endtask

    // Monitor: one-hot-or-zero every cycle and at least DEAD idle cycles
    // between two different enabled designs.
    initial begin
        logic [ND-1:0] last_nz;
        int            zrun;
        last_nz = '0;
        zrun    = 0;
        forever begin
            @(negedge clk);
            chk("onehot0", 32'($onehot0(active)), 32'd1);
            if (active == '0) begin
                zrun++;
            end else begin
                if (last_nz != '0 && active != last_nz)
                    chk("min_gap", 32'(zrun >= DEAD), 32'd1);
                last_nz = active;
                zrun    = 0;
            end
        end
    end

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        sel_valid = 1'b0;
        sel_en    = 1'b0;
        sel_id    = '0;
        kill      = 1'b0;
        #12;
        chk("rst_active", 32'(active), 32'd0);
        chk("rst_ready",  32'(sel_ready), 32'd1);
        chk("rst_curon",  32'(cur_on), 32'd0);
        chk("rst_curid",  32'(cur_id), 32'd0);
        chk("rst_done",   32'(done), 32'd0);
        chk("rst_err",    32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // OFF -> ON id 1, then ON 1 -> ON 0.
        switch_to("sw1", 2'd1);
        switch_to("sw0", 2'd0);

        // No-op on the already enabled design.
        req(1'b1, 2'd0);
        chk("noop_done",   32'(done), 32'd1);
        chk("noop_active", 32'(active), 32'b001);
        chk("noop_ready",  32'(sel_ready), 32'd1);
        step();
        chk("noop_clr",    32'(done), 32'd0);

        // Out-of-range id is rejected.
        req(1'b1, 2'd3);
        chk("rej_err",    32'(err), 32'd1);
        chk("rej_done",   32'(done), 32'd0);
        chk("rej_active", 32'(active), 32'b001);
        chk("rej_curid",  32'(cur_id), 32'd0);
        step();
        chk("rej_clr",    32'(err), 32'd0);

        // Off request from ON, then from OFF.
        req(1'b0, 2'd0);
        chk("off_active", 32'(active), 32'd0);
        chk("off_done",   32'(done), 32'd1);
        chk("off_curon",  32'(cur_on), 32'd0);
        chk("off_ready",  32'(sel_ready), 32'd1);
        req(1'b0, 2'd0);
        chk("off2_done",  32'(done), 32'd1);
        chk("off2_curon", 32'(cur_on), 32'd0);
        step();

        // Kill two cycles into a gap, with a request presented at the same edge.
        req(1'b1, 2'd2);
        step();
        step();
        kill      = 1'b1;
        sel_valid = 1'b1;
        sel_en    = 1'b1;
        sel_id    = 2'd1;
        step();
        kill      = 1'b0;
        sel_valid = 1'b0;
        chk("kgap_active", 32'(active), 32'd0);
        chk("kgap_curon",  32'(cur_on), 32'd0);
        chk("kgap_ready",  32'(sel_ready), 32'd1);
        chk("kgap_done",   32'(done), 32'd0);
        chk("kgap_err",    32'(err), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("kgap_nodone", 32'(done), 32'd0);
            chk("kgap_stayoff", 32'(active), 32'd0);
        end
        switch_to("after_kill", 2'd2);

        // Kill while ON beats a simultaneous accepted (invalid) request.
        kill      = 1'b1;
        sel_valid = 1'b1;
        sel_en    = 1'b1;
        sel_id    = 2'd3;
        step();
        kill      = 1'b0;
        sel_valid = 1'b0;
        chk("kon_active", 32'(active), 32'd0);
        chk("kon_curon",  32'(cur_on), 32'd0);
        chk("kon_err",    32'(err), 32'd0);
        chk("kon_done",   32'(done), 32'd0);
        chk("kon_curid",  32'(cur_id), 32'd2);

        // Asynchronous reset mid-ON.
        switch_to("pre_rst", 2'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_active", 32'(active), 32'd0);
        chk("arst_curon",  32'(cur_on), 32'd0);
        chk("arst_ready",  32'(sel_ready), 32'd1);
        chk("arst_curid",  32'(cur_id), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_rst_ready", 32'(sel_ready), 32'd1);
        chk("post_rst_curon", 32'(cur_on), 32'd0);

        // Random stream; the monitor guards the invariants.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            sel_valid = ($urandom_range(0, 3) == 0);
            sel_en    = ($urandom_range(0, 3) != 0);
            sel_id    = IW'($urandom_range(0, 3));
            kill      = ($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 300) == 0) begin
                #2 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
        end
        @(negedge clk);
        sel_valid = 1'b0;
        kill      = 1'b0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
